// File: rtl/irq_arbiter_if.sv
// Register bus and interrupt outputs of irq_arbiter.
//   master: drives addr_in/data_in/wr, observes rd_data/irq/irq_id (CPU / I/O controller side)
//   slave : the arbiter itself
interface irq_arbiter_if;
  logic [31:0] addr_in;
  logic [31:0] data_in;
  logic        wr;
  logic [31:0] rd_data;
  logic        irq;
  logic [3:0]  irq_id;

  modport master (output addr_in, data_in, wr, input rd_data, irq, irq_id);
  modport slave  (input addr_in, data_in, wr, output rd_data, irq, irq_id);
endinterface

// File: rtl/irq_arbiter.sv
// Memory-mapped round-robin interrupt arbiter.
// Latches edge-type requests, follows level-type requests with one cycle delay,
// masks with EN, grants one source to the CPU via irq/irq_id until EOI is written.
// Ports:
//   clk    system clock
//   reset  synchronous active-high reset
//   src    NSRC request inputs, synchronous to clk
//   bus    register bus (addr_in, data_in, wr, rd_data) and irq/irq_id outputs
// Registers (addr_in[3:2]): 0 PEND (W1C edge bits), 1 EN, 2 CAUSE, 3 EOI.
module irq_arbiter #(
  parameter int unsigned           NSRC      = 4,
  parameter logic [NSRC-1:0]       EDGE_MASK = NSRC'(1),
  parameter logic [3:0]            BASE      = 4'hE
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src,
  irq_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

  state_t          state, state_next;
  logic [NSRC-1:0] src_q;
  logic [NSRC-1:0] pending, pending_next;
  logic [NSRC-1:0] enable;
  logic [NSRC-1:0] req;
  logic [NSRC-1:0] gmask;
  logic [3:0]      rr_ptr, rr_next;
  logic [3:0]      irq_id_r;
  logic [3:0]      winner;
  logic            found;
  logic            grant;
  logic            sel;
  logic [1:0]      idx;
  logic            wr_pend, wr_en, wr_eoi;
  logic            active;

  logic unused_bits;
  assign unused_bits = ^{bus.addr_in[27:4], bus.addr_in[1:0], bus.data_in};

  assign sel     = (bus.addr_in[31:28] == BASE);
  assign idx     = bus.addr_in[3:2];
  assign wr_pend = sel & bus.wr & (idx == 2'd0);
  assign wr_en   = sel & bus.wr & (idx == 2'd1);
  assign wr_eoi  = sel & bus.wr & (idx == 2'd3);
  assign req     = pending & enable;
  assign active  = (state == ACTIVE);

  // Round-robin search: rotate req right by rr_ptr so bit 0 is the first
  // candidate, take the lowest set bit, then map it back to a source index.
  always_comb begin
    logic [2*NSRC-1:0] rot;
    logic [4:0]        sum;
    rot    = {req, req} >> rr_ptr;
    found  = 1'b0;
    sum    = '0;
    winner = '0;
    for (int unsigned j = 0; j < NSRC; j++) begin
      if (!found && rot[j]) begin
        found = 1'b1;
        sum   = {1'b0, rr_ptr} + 5'(j);
      end
    end
    winner = (sum >= 5'(NSRC)) ? 4'(sum - 5'(NSRC)) : sum[3:0];
    rr_next = (({1'b0, winner} + 5'd1) == 5'(NSRC)) ? 4'd0 : (winner + 4'd1);
    for (int unsigned i = 0; i < NSRC; i++) begin
      gmask[i] = (winner == 4'(i));
    end
  end

  always_comb begin
    state_next = state;
    grant      = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          grant      = 1'b1;
          state_next = ACTIVE;
        end
      end
      ACTIVE: if (wr_eoi) state_next = DRAIN;
      DRAIN:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Edge bits: set wins over W1C and grant-clear. Level bits just track src.
  always_comb begin
    pending_next = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (EDGE_MASK[i]) begin
        pending_next[i] = (src[i] & ~src_q[i]) |
                          (pending[i] & ~((wr_pend & bus.data_in[i]) | (grant & gmask[i])));
      end else begin
        pending_next[i] = src[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    src_q <= src;
    if (reset) begin
      state    <= IDLE;
      pending  <= '0;
      enable   <= '0;
      rr_ptr   <= '0;
      irq_id_r <= '0;
    end else begin
      state   <= state_next;
      pending <= pending_next;
      if (wr_en) enable <= bus.data_in[NSRC-1:0];
      if (grant) begin
        irq_id_r <= winner;
        rr_ptr   <= rr_next;
      end
    end
  end

  always_comb begin
    bus.rd_data = '0;
    if (sel) begin
      case (idx)
        2'd0:    bus.rd_data = 32'(pending);
        2'd1:    bus.rd_data = 32'(enable);
        2'd2:    bus.rd_data = {active, 27'b0, irq_id_r};
        default: bus.rd_data = '0;
      endcase
    end
  end

  assign bus.irq    = active;
  assign bus.irq_id = irq_id_r;

endmodule
